// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the buffered UART transmitter.
//   UART_DATA_W - width of one serial data byte
//   tx_state_t  - transmit FSM states
//   count_w()   - width of an occupancy counter able to hold 0..depth
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  // One extra bit over the address width so that "full" (== depth) is representable.
  function automatic int count_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: small synchronous FIFO feeding the UART transmit FSM.
//   clock    - system clock, rising edge
//   reset    - synchronous active-low reset (empties the FIFO)
//   i_push   - write i_wdata this edge (ignored while full)
//   i_wdata  - data to write
//   i_pop    - discard head entry this edge (ignored while empty)
//   o_rdata  - current head entry (valid while !o_empty)
//   o_count  - occupied entries, 0..DEPTH
//   o_full   - o_count == DEPTH
//   o_empty  - o_count == 0
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = UART_DATA_W
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      i_push,
  input  logic [WIDTH-1:0]          i_wdata,
  input  logic                      i_pop,
  output logic [WIDTH-1:0]          o_rdata,
  output logic [count_w(DEPTH)-1:0] o_count,
  output logic                      o_full,
  output logic                      o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = count_w(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  // Overflow/underflow requests are dropped so the count can never leave 0..DEPTH.
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rptr];

  // Storage, pointers (wrap naturally since DEPTH is a power of two) and occupancy.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        r_mem[k] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= i_wdata;
        r_wptr        <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: buffered 8N(STOP_BITS) UART transmitter.
//   clock      - system clock, rising edge
//   reset      - synchronous active-low reset; abandons any frame in flight
//   tx_data    - byte to queue
//   tx_valid   - tx_data valid; accepted on an edge where tx_valid && tx_ready
//   tx_ready   - FIFO has room (from the registered occupancy)
//   serial_out - registered serial line, idles high
//   busy       - a frame is being sent (FSM not idle)
//   fifo_count - bytes waiting in the FIFO
// Frame: start(0), 8 data bits LSB first, STOP_BITS stop bits(1), each bit
// CLKS_PER_BIT clocks long. Queued bytes follow each other with no idle gap.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1,
  parameter int STOP_BITS    = 2,
  parameter int DEPTH        = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [7:0]                tx_data,
  input  logic                      tx_valid,
  output logic                      tx_ready,
  output logic                      serial_out,
  output logic                      busy,
  output logic [count_w(DEPTH)-1:0] fifo_count
);

  localparam logic [15:0] BAUD_RELOAD = 16'(CLKS_PER_BIT - 1);
  localparam logic [1:0]  LAST_STOP   = 2'(STOP_BITS - 1);

  tx_state_t        r_state;
  logic             r_serial;
  logic [15:0]      r_baud;
  logic [2:0]       r_bit_idx;
  logic [1:0]       r_stop_cnt;
  logic [7:0]       r_shift;

  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic             w_bit_end;
  logic [7:0]       w_rdata;

  assign tx_ready   = !w_full;
  assign w_push     = tx_valid && tx_ready;
  assign w_bit_end  = (r_baud == 16'd0);
  assign serial_out = r_serial;
  assign busy       = (r_state != IDLE);

  uart_tx_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (UART_DATA_W)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .i_push  (w_push),
    .i_wdata (tx_data),
    .i_pop   (w_pop),
    .o_rdata (w_rdata),
    .o_count (fifo_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // A byte is loaded either from idle or straight at the end of the last stop bit.
  always_comb begin
    w_pop = 1'b0;
    case (r_state)
      IDLE: w_pop = !w_empty;
      STOP: begin
        if (w_bit_end && (r_stop_cnt == LAST_STOP)) begin
          w_pop = !w_empty;
        end else begin
          w_pop = 1'b0;
        end
      end
      default: w_pop = 1'b0;
    endcase
  end

  // Transmit FSM, baud counter and shifter; serial_out is registered here.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_serial   <= 1'b1;
      r_baud     <= 16'd0;
      r_bit_idx  <= 3'd0;
      r_stop_cnt <= 2'd0;
      r_shift    <= 8'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_shift  <= w_rdata;
            r_serial <= 1'b0;
            r_baud   <= BAUD_RELOAD;
            r_state  <= START;
          end else begin
            r_serial <= 1'b1;
          end
        end
        START: begin
          if (w_bit_end) begin
            r_baud    <= BAUD_RELOAD;
            r_bit_idx <= 3'd0;
            r_serial  <= r_shift[0];
            r_state   <= DATA;
          end else begin
            r_baud <= r_baud - 16'd1;
          end
        end
        DATA: begin
          if (w_bit_end) begin
            r_baud <= BAUD_RELOAD;
            if (r_bit_idx == 3'd7) begin
              r_serial   <= 1'b1;
              r_stop_cnt <= 2'd0;
              r_state    <= STOP;
            end else begin
              // Next bit on the line is the one that becomes shift[0] after this shift.
              r_shift   <= {1'b0, r_shift[7:1]};
              r_serial  <= r_shift[1];
              r_bit_idx <= r_bit_idx + 3'd1;
            end
          end else begin
            r_baud <= r_baud - 16'd1;
          end
        end
        STOP: begin
          if (w_bit_end) begin
            r_baud <= BAUD_RELOAD;
            if (r_stop_cnt == LAST_STOP) begin
              if (w_pop) begin
                r_shift  <= w_rdata;
                r_serial <= 1'b0;
                r_state  <= START;
              end else begin
                r_state <= IDLE;
              end
            end else begin
              r_stop_cnt <= r_stop_cnt + 2'd1;
            end
          end else begin
            r_baud <= r_baud - 16'd1;
          end
        end
        default: begin
          r_state  <= IDLE;
          r_serial <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// tb_uart_tx_buffered: two transmitter lanes (lane0: 1 clk/bit, 2 stop bits;
// lane1: 4 clks/bit, 1 stop bit) checked every cycle against a queue-based
// line model, plus directed scenarios with literal expectations.
module tb_uart_tx_buffered;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic [1:0]      rstn;
  logic [1:0]      tv;
  logic [1:0][7:0] td;
  logic [1:0]      ready_w;
  logic [1:0]      ser_w;
  logic [1:0]      busy_w;
  logic [1:0][2:0] cnt_w;

  int   n_err = 0;
  int   n_chk = 0;
  bit   chk_en = 1'b0;

  // model-side observables, one slot per lane
  int   m_lq[2];
  int   m_cnt[2];
  bit   m_ser[2];
  bit   m_busy[2];
  bit   m_inrst[2];

  logic [7:0] rx_buf[2][256];
  int         rx_n[2] = '{0, 0};
  logic [7:0] pl_buf[2][256];
  int         pl_n[2] = '{0, 0};

  int obs_max;
  int obs_blk;

  task automatic check(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_lane
    localparam int CPB = (g == 0) ? 1 : 4;
    localparam int SB  = (g == 0) ? 2 : 1;

    uart_tx_buffered #(
      .CLKS_PER_BIT (CPB),
      .STOP_BITS    (SB),
      .DEPTH        (4)
    ) dut (
      .clock      (clock),
      .reset      (rstn[g]),
      .tx_data    (td[g]),
      .tx_valid   (tv[g]),
      .tx_ready   (ready_w[g]),
      .serial_out (ser_w[g]),
      .busy       (busy_w[g]),
      .fifo_count (cnt_w[g])
    );

    logic [7:0] mq[$];
    bit         lq[$];

    // Line model: a byte queue plus a queue of future line levels.
    initial begin : model
      logic [7:0] b;
      bit         push;
      m_ser[g] = 1'b1; m_busy[g] = 1'b0; m_inrst[g] = 1'b1;
      m_lq[g] = 0; m_cnt[g] = 0;
      forever begin
        @(posedge clock);
        if (!rstn[g]) begin
          mq.delete();
          lq.delete();
          m_ser[g] = 1'b1;
          m_busy[g] = 1'b0;
          m_inrst[g] = 1'b1;
        end else begin
          m_inrst[g] = 1'b0;
          push = tv[g] && (mq.size() < 4);
          if (lq.size() == 0 && mq.size() > 0) begin
            b = mq.pop_front();
            for (int k = 0; k < 9 + SB; k++) begin
              for (int r = 0; r < CPB; r++) begin
                lq.push_back((k == 0) ? 1'b0 : ((k <= 8) ? b[k-1] : 1'b1));
              end
            end
          end
          if (lq.size() > 0) begin
            m_ser[g] = lq.pop_front();
            m_busy[g] = 1'b1;
          end else begin
            m_ser[g] = 1'b1;
            m_busy[g] = 1'b0;
          end
          if (push) begin
            mq.push_back(td[g]);
            pl_buf[g][pl_n[g] % 256] = td[g];
            pl_n[g]++;
          end
        end
        m_lq[g] = lq.size();
        m_cnt[g] = mq.size();
      end
    end

    // Per-cycle compare and a frame decoder on the DUT line.
    initial begin : mon
      int t;
      bit act;
      logic [7:0] d;
      act = 1'b0; t = 0; d = 8'h00;
      forever begin
        @(negedge clock);
        if (chk_en) begin
          check($sformatf("lane%0d serial_out", g), int'(ser_w[g]), int'(m_ser[g]));
          check($sformatf("lane%0d busy", g), int'(busy_w[g]), int'(m_busy[g]));
          check($sformatf("lane%0d fifo_count", g), int'(cnt_w[g]), m_cnt[g]);
          check($sformatf("lane%0d tx_ready", g), int'(ready_w[g]), int'(m_cnt[g] < 4));
          if (m_inrst[g]) begin
            act = 1'b0;
          end else if (!act) begin
            if (ser_w[g] == 1'b0) begin
              act = 1'b1; t = 0; d = 8'h00;
            end
          end else begin
            t++;
            if (t % CPB == 0) begin
              if (t / CPB <= 8) begin
                d[t/CPB-1] = ser_w[g];
              end else begin
                check($sformatf("lane%0d stop bit", g), int'(ser_w[g]), 1);
                rx_buf[g][rx_n[g] % 256] = d;
                rx_n[g]++;
                act = 1'b0;
              end
            end
          end
        end
      end
    end
  end

  // Offer a byte and hold it until the model says it was taken (call at a negedge).
  task automatic send(input int g, input logic [7:0] d);
    tv[g] = 1'b1;
    td[g] = d;
    for (int k = 0; k < 300; k++) begin
      if (int'(cnt_w[g]) > obs_max) obs_max = int'(cnt_w[g]);
      if (!ready_w[g]) obs_blk++;
      if (m_cnt[g] < 4) begin
        @(negedge clock);
        return;
      end
      @(negedge clock);
    end
    n_chk++;
    n_err++;
    $display("FAIL send timeout lane%0d: byte %0h not accepted, required within 300 cycles", g, d);
  endtask

  // Count busy cycles and the longest busy run over n cycles, from the current one.
  task automatic watch(input int g, input int n, output int bn, output int run);
    int cur;
    bn = 0; run = 0; cur = 0;
    for (int j = 0; j < n; j++) begin
      if (busy_w[g]) begin
        bn++; cur++;
        if (cur > run) run = cur;
      end else begin
        cur = 0;
      end
      @(negedge clock);
    end
  endtask

  task automatic wait_lq(input int g, input int target);
    for (int k = 0; k < 200; k++) begin
      if (m_lq[g] == target) return;
      @(negedge clock);
    end
    n_chk++;
    n_err++;
    $display("FAIL wait_lq timeout lane%0d: line queue %0d, required %0d", g, m_lq[g], target);
  endtask

  initial begin : main
    int bn, run, base, pbase, e, nrx, npl;
    logic [10:0] a5_exp;
    logic [7:0]  ebyte;

    rstn = 2'b00; tv = 2'b00; td = '0; obs_max = 0; obs_blk = 0;
    @(negedge clock);
    chk_en = 1'b1;
    @(negedge clock);
    for (int g = 0; g < 2; g++) begin
      check("reset serial_out", int'(ser_w[g]), 1);
      check("reset busy", int'(busy_w[g]), 0);
      check("reset fifo_count", int'(cnt_w[g]), 0);
      check("reset tx_ready", int'(ready_w[g]), 1);
    end
    rstn = 2'b11;
    @(negedge clock);

    // single byte 0xA5 on lane0
    a5_exp = 11'b111_0100_1010;
    base = rx_n[0];
    send(0, 8'hA5);
    tv[0] = 1'b0;
    check("a5 line before first pop", int'(ser_w[0]), 1);
    bn = 0;
    for (int j = 0; j < 15; j++) begin
      @(negedge clock);
      e = (j < 11) ? int'(a5_exp[j]) : 1;
      check($sformatf("a5 line cycle %0d", j), int'(ser_w[0]), e);
      if (busy_w[0]) bn++;
    end
    check("a5 busy cycles", bn, 11);
    check("a5 decoded count", rx_n[0] - base, 1);
    check("a5 decoded byte", int'(rx_buf[0][base % 256]), 8'hA5);

    // back-to-back 0x3C, 0xC3
    base = rx_n[0];
    send(0, 8'h3C);
    send(0, 8'hC3);
    tv[0] = 1'b0;
    watch(0, 30, bn, run);
    check("b2b busy cycles", bn, 22);
    check("b2b busy run", run, 22);
    check("b2b decoded count", rx_n[0] - base, 2);
    check("b2b byte0", int'(rx_buf[0][base % 256]), 8'h3C);
    check("b2b byte1", int'(rx_buf[0][(base + 1) % 256]), 8'hC3);

    // backpressure: six bytes with tx_valid held
    base = rx_n[0];
    obs_max = 0; obs_blk = 0;
    for (int k = 0; k < 6; k++) send(0, 8'(17 * (k + 1)));
    tv[0] = 1'b0;
    watch(0, 100, bn, run);
    check("bp max fifo_count", obs_max, 4);
    check("bp tx_ready low seen", int'(obs_blk > 0), 1);
    check("bp decoded count", rx_n[0] - base, 6);
    for (int k = 0; k < 6; k++)
      check($sformatf("bp byte%0d", k), int'(rx_buf[0][(base + k) % 256]), 17 * (k + 1));

    // reset during data bit 3 with two bytes queued
    send(0, 8'hD1);
    send(0, 8'hD2);
    send(0, 8'hD3);
    tv[0] = 1'b0;
    wait_lq(0, 6);
    check("mid-frame queued", int'(cnt_w[0]), 2);
    rstn[0] = 1'b0;
    @(negedge clock);
    check("mid rst serial_out", int'(ser_w[0]), 1);
    check("mid rst busy", int'(busy_w[0]), 0);
    check("mid rst fifo_count", int'(cnt_w[0]), 0);
    check("mid rst tx_ready", int'(ready_w[0]), 1);
    rstn[0] = 1'b1;
    base = rx_n[0];
    watch(0, 40, bn, run);
    check("post rst busy cycles", bn, 0);
    check("post rst decoded count", rx_n[0] - base, 0);

    // push offered on the edge a frame ends with the FIFO full
    base = rx_n[0];
    for (int k = 0; k < 5; k++) send(0, 8'(8'hE1 + k));
    tv[0] = 1'b1;
    td[0] = 8'hE6;
    wait_lq(0, 0);
    check("full ready before end", int'(ready_w[0]), 0);
    check("full count before end", int'(cnt_w[0]), 4);
    @(negedge clock);
    check("ready after pop", int'(ready_w[0]), 1);
    check("count after pop", int'(cnt_w[0]), 3);
    @(negedge clock);
    check("count after late push", int'(cnt_w[0]), 4);
    tv[0] = 1'b0;
    watch(0, 80, bn, run);
    check("simul decoded count", rx_n[0] - base, 6);
    for (int k = 0; k < 6; k++)
      check($sformatf("simul byte%0d", k), int'(rx_buf[0][(base + k) % 256]), 8'hE1 + k);

    // baud scaling on lane1: 0x01, 4 clocks/bit, 1 stop bit
    base = rx_n[1];
    send(1, 8'h01);
    tv[1] = 1'b0;
    bn = 0;
    for (int j = 0; j < 50; j++) begin
      @(negedge clock);
      e = (j < 4) ? 0 : (j < 8) ? 1 : (j < 36) ? 0 : 1;
      check($sformatf("baud line cycle %0d", j), int'(ser_w[1]), e);
      if (busy_w[1]) bn++;
    end
    check("baud busy cycles", bn, 40);
    check("baud decoded count", rx_n[1] - base, 1);
    check("baud decoded byte", int'(rx_buf[1][base % 256]), 8'h01);

    // random traffic on both lanes
    base = rx_n[0];
    pbase = pl_n[0];
    bn = rx_n[1];
    run = pl_n[1];
    for (int c = 0; c < 400; c++) begin
      tv[0] = ($urandom_range(0, 2) == 0);
      td[0] = 8'($urandom);
      tv[1] = ($urandom_range(0, 2) == 0);
      td[1] = 8'($urandom);
      @(negedge clock);
    end
    tv = 2'b00;
    repeat (400) @(negedge clock);
    for (int g = 0; g < 2; g++) begin
      nrx = rx_n[g] - ((g == 0) ? base : bn);
      npl = pl_n[g] - ((g == 0) ? pbase : run);
      check($sformatf("rand lane%0d byte count", g), nrx, npl);
      for (int k = 0; k < nrx && k < npl; k++) begin
        ebyte = pl_buf[g][(((g == 0) ? pbase : run) + k) % 256];
        check($sformatf("rand lane%0d byte%0d", g, k),
              int'(rx_buf[g][(((g == 0) ? base : bn) + k) % 256]), int'(ebyte));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
